// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 register bank: write-mode encodings and the
// address-width helper.
package mu0_pkg;

  localparam logic [1:0] MU0_MODE_LOAD = 2'b00;
  localparam logic [1:0] MU0_MODE_INC  = 2'b01;
  localparam logic [1:0] MU0_MODE_DEC  = 2'b10;
  localparam logic [1:0] MU0_MODE_CLR  = 2'b11;

  // Address width for a bank of 'depth' entries; never narrower than 1 bit.
  function automatic int mu0_aw(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/mu0_reg_cell.sv
// One bank register: applies the selected mode when enabled and exposes its
// combinational next value and wrap detect so the bank can bypass and flag.
module mu0_reg_cell
  import mu0_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] next_val,
  output logic             wrap_det
);

  always_comb begin
    next_val = Q;
    unique case (Mode)
      MU0_MODE_LOAD: next_val = D;
      MU0_MODE_INC:  next_val = Q + WIDTH'(1);
      MU0_MODE_DEC:  next_val = Q - WIDTH'(1);
      MU0_MODE_CLR:  next_val = '0;
      default:       next_val = Q;
    endcase
  end

  assign wrap_det = ((Mode == MU0_MODE_INC) && (&Q)) ||
                    ((Mode == MU0_MODE_DEC) && (~|Q));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)  Q <= RESET_VAL;
    else if (En) Q <= next_val;
  end

endmodule

// File: rtl/mu0_regbank.sv
// DEPTH x WIDTH register bank with one write/modify port, two combinational
// read ports, optional write-through bypass and a registered wrap flag.
module mu0_regbank
  import mu0_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               BYPASS    = 1'b0,
  localparam int              AW        = mu0_aw(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WEn,
  input  logic [1:0]       WMode,
  input  logic [AW-1:0]    WAddr,
  input  logic [WIDTH-1:0] WData,
  input  logic [AW-1:0]    RAddrA,
  input  logic [AW-1:0]    RAddrB,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  output logic             Wrap
);

  logic [DEPTH-1:0][WIDTH-1:0] q, nxt;
  logic [DEPTH-1:0]            en, wdet;
  logic [WIDTH-1:0]            w_next;
  logic                        w_hit, w_wrap, byp_a, byp_b;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    assign en[i] = WEn && (WAddr == AW'(i));
    mu0_reg_cell #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_cell (
      .Clk     (Clk),
      .Reset   (Reset),
      .En      (en[i]),
      .Mode    (WMode),
      .D       (WData),
      .Q       (q[i]),
      .next_val(nxt[i]),
      .wrap_det(wdet[i])
    );
  end

  // Out-of-range write addresses never match, so they write nothing and
  // leave w_wrap low.
  always_comb begin
    w_next = '0;
    w_hit  = 1'b0;
    w_wrap = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (WAddr == AW'(i)) begin
        w_next = nxt[i];
        w_hit  = 1'b1;
        w_wrap = wdet[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) Wrap <= 1'b0;
    else        Wrap <= WEn && w_wrap;
  end

  assign byp_a = BYPASS && Reset && WEn && w_hit && (RAddrA == WAddr);
  assign byp_b = BYPASS && Reset && WEn && w_hit && (RAddrB == WAddr);

  always_comb begin
    QA = '0;
    QB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RAddrA == AW'(i)) QA = q[i];
      if (RAddrB == AW'(i)) QB = q[i];
    end
    if (byp_a) QA = w_next;
    if (byp_b) QB = w_next;
  end

endmodule

// File: tb/tb_mu0_regbank.sv
// Scoreboard bench: a default bank and a DEPTH=3 bypass bank share one stimulus
// stream and are checked against an arithmetic reference model.
module tb_mu0_regbank;

  logic        Clk = 1'b0, Reset = 1'b0, WEn = 1'b0;
  logic [1:0]  WMode = '0, WAddr = '0, RAddrA = '0, RAddrB = '0;
  logic [15:0] WData = '0;
  logic [15:0] qa0, qb0, qa1, qb1;
  logic        wrap0, wrap1;

  always #25 Clk = ~Clk;

  mu0_regbank #(.WIDTH(16), .DEPTH(4), .RESET_VAL(16'h0000), .BYPASS(1'b0)) dut_a (
    .Clk(Clk), .Reset(Reset), .WEn(WEn), .WMode(WMode), .WAddr(WAddr), .WData(WData),
    .RAddrA(RAddrA), .RAddrB(RAddrB), .QA(qa0), .QB(qb0), .Wrap(wrap0));

  mu0_regbank #(.WIDTH(16), .DEPTH(3), .RESET_VAL(16'h0000), .BYPASS(1'b1)) dut_b (
    .Clk(Clk), .Reset(Reset), .WEn(WEn), .WMode(WMode), .WAddr(WAddr), .WData(WData),
    .RAddrA(RAddrA), .RAddrB(RAddrB), .QA(qa1), .QB(qb1), .Wrap(wrap1));

  typedef struct {
    int          idx;
    logic [15:0] qa0, qb0, qa1, qb1;
    logic        w0, w1;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0, n_bad = 0, n_step = 0;
  int   m0[4];
  int   m1[3];
  bit   mw0, mw1;

  task automatic chk(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) m0[i] = 0;
    for (int i = 0; i < 3; i++) m1[i] = 0;
    mw0 = 0;
    mw1 = 0;
  endtask

  // Register result of applying 'mode' to value v, with wrap reported.
  function automatic int apply(input int v, input int mode, input int d, output bit wr);
    int r;
    wr = 0;
    case (mode)
      0: r = d;
      1: begin r = v + 1; if (r > 65535) begin r = 0; wr = 1; end end
      2: begin r = v - 1; if (r < 0) begin r = 65535; wr = 1; end end
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic int rd1(input int a);
    return (a < 3) ? m1[a] : 0;
  endfunction

  task automatic step(input bit rst, input bit wen, input int mode, input int waddr,
                      input int wdata, input int ra, input int rb);
    exp_t e;
    int   n0, n1;
    bit   r0, r1;
    @(posedge Clk);
    #2;
    Reset = rst; WEn = wen; WMode = mode[1:0]; WAddr = waddr[1:0];
    WData = wdata[15:0]; RAddrA = ra[1:0]; RAddrB = rb[1:0];
    if (!rst) reset_model();
    r1 = 0;
    n1 = 0;
    n0 = apply(m0[waddr], mode, wdata, r0);
    if (waddr < 3) n1 = apply(m1[waddr], mode, wdata, r1);
    e.idx = n_step;
    e.w0  = mw0;
    e.w1  = mw1;
    e.qa0 = 16'(m0[ra]);
    e.qb0 = 16'(m0[rb]);
    e.qa1 = (rst && wen && waddr < 3 && ra == waddr) ? 16'(n1) : 16'(rd1(ra));
    e.qb1 = (rst && wen && waddr < 3 && rb == waddr) ? 16'(n1) : 16'(rd1(rb));
    sbq.push_back(e);
    n_step++;
    if (rst) begin
      mw0 = wen && r0;
      mw1 = wen && (waddr < 3) && r1;
      if (wen) m0[waddr] = n0;
      if (wen && waddr < 3) m1[waddr] = n1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #10;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("qa0",   e.idx, qa0, e.qa0);
        chk("qb0",   e.idx, qb0, e.qb0);
        chk("qa1",   e.idx, qa1, e.qa1);
        chk("qb1",   e.idx, qb1, e.qb1);
        chk("wrap0", e.idx, {15'b0, wrap0}, {15'b0, e.w0});
        chk("wrap1", e.idx, {15'b0, wrap1}, {15'b0, e.w1});
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : driver
    reset_model();
    // Held in reset with a load pending, then released.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 16'hAAAA, 0, 1);
    step(1, 1, 0, 0, 16'hAAAA, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 2, 3);
    // Wrap on increment and decrement.
    step(1, 1, 0, 2, 16'hFFFF, 2, 0);
    step(1, 1, 1, 2, 0, 2, 0);
    step(1, 1, 2, 2, 0, 2, 0);
    step(1, 0, 0, 2, 0, 2, 0);
    step(1, 0, 0, 2, 0, 2, 0);
    // Hold with WEn low, then clear.
    step(1, 1, 0, 1, 16'h1234, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 16'hBBBB, 1, 0);
    step(1, 1, 3, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0, 1, 0);
    // Read-during-write on both ports, in and out of range for the small bank.
    step(1, 1, 0, 3, 16'h5A5A, 3, 3);
    step(1, 1, 0, 2, 16'hC3C3, 2, 2);
    step(1, 0, 0, 0, 0, 3, 2);
    step(1, 1, 0, 3, 16'hCCCC, 3, 0);
    step(1, 0, 0, 0, 0, 3, 2);
    // Asynchronous reset mid-cycle with an increment pending.
    step(1, 1, 0, 0, 16'hAAAA, 0, 1);
    step(1, 1, 1, 0, 0, 0, 1);
    #23;
    Reset = 1'b0;
    reset_model();
    #5;
    chk("async_rst qa0", n_step, qa0, 16'h0000);
    chk("async_rst qa1", n_step, qa1, 16'h0000);
    step(0, 1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    // Randomized traffic, with occasional resets and frequent wrap corners.
    for (int i = 0; i < 400; i++) begin
      int d;
      case ($urandom_range(0, 3))
        0: d = 16'hFFFF;
        1: d = 0;
        default: d = int'($urandom_range(0, 65535));
      endcase
      step($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    @(posedge Clk);
    #20;
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mu0_regbank.md
Name: mu0_regbank

Overview:
Parametrised successor to the single MU0 12-bit enable register: a bank of DEPTH registers of WIDTH bits with one write/modify port and two combinational read ports. Each write cycle applies a mode operation (load, increment, decrement, clear) to the addressed register. The bank has an optional write-to-read bypass and a registered wrap flag. It is the storage for MU0 datapath registers such as ACC, PC and scratch registers.

Parameters:
WIDTH, 16, data width of every register (>=2)
DEPTH, 4, number of registers (>=2; need not be a power of two)
RESET_VAL, 0, value loaded into every register on reset (WIDTH bits)
BYPASS, 0, 1 = read port returns the value being written this cycle on an address match

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous reset, active-low (0 = reset asserted)
WEn  input  1  write/modify enable
WMode  input  2  operation: 00 load, 01 increment, 10 decrement, 11 clear
WAddr  input  AW  target register; AW = max(1, clog2(DEPTH))
WData  input  WIDTH  load data (used only in mode 00)
RAddrA  input  AW  read address, port A
RAddrB  input  AW  read address, port B
QA  output  WIDTH  read data, port A
QB  output  WIDTH  read data, port B
Wrap  output  1  registered flag; high for one cycle after an inc/dec wraps

Behaviour:
- Reset low: all registers and Wrap go to RESET_VAL / 0 immediately, with no wait for Clk. While Reset is low, WEn is ignored.
- Reset rising edge: the first clock edge with Reset high may perform a write.
- On a rising Clk with Reset high and WEn=1 and WAddr<DEPTH, the addressed register takes its next value:
  - load: WData
  - inc: reg+1, modulo 2^WIDTH
  - dec: reg-1, modulo 2^WIDTH
  - clear: 0. Clear ignores RESET_VAL.
- WEn=0: every register holds.
- Only the addressed register changes. All other registers hold.
- WAddr>=DEPTH: the write is ignored, no register changes, and Wrap is 0 next cycle.
- Wrap: registered, so it is valid the cycle after the edge. Wrap is set to 1 at an edge where the applied op is inc of all-ones (result 0) or dec of 0 (result all-ones). At every other edge Wrap is set to 0. Load and clear never set Wrap.
- Reads are combinational: QA = reg[RAddrA], QB = reg[RAddrB]. An out-of-range read address returns 0.
- Both ports may read the same address at once, with identical results.
- BYPASS=0: a read of the register being written returns the old value until the edge.
- BYPASS=1: a read with RAddr==WAddr, WEn=1 and Reset high returns the computed next value (load/inc/dec/clear result) in the same cycle.
- Latency: write visible on Q one edge later (0 with BYPASS=1). Wrap lags the causing edge by one cycle.
- Reset asserted mid-cycle with WEn=1: reset wins and no write occurs.
- No X propagation: all outputs are defined from reset onward.

Decomposition:
- Shared package mu0_pkg holds:
  - mode constants MU0_MODE_LOAD=2'b00, MU0_MODE_INC=2'b01, MU0_MODE_DEC=2'b10, MU0_MODE_CLR=2'b11
  - an AW helper function (clog2 with minimum 1)
- Sub-module mu0_reg_cell: one WIDTH register with Clk, Reset, En, Mode, D, RESET_VAL. It outputs Q, its combinational next value (used for bypass) and a wrap-detect signal.
- mu0_regbank instantiates DEPTH cells with a generate loop. It also contains the write-address decode, the two read muxes, the bypass compare and the Wrap register.

Test Plan:
1. Reset low for 200ns while WEn=1, WMode=load, WData=16'hAAAA, WAddr=0 -> all regs read 16'h0000 and Wrap=0. Deassert Reset, one edge -> reg0=16'hAAAA and reg1..3 unchanged at 0.
2. Load reg2=16'hFFFF, then inc reg2 -> reg2=16'h0000 and Wrap=1 for exactly one cycle. Dec reg2 -> 16'hFFFF with Wrap=1 again. Next idle cycle -> Wrap=0.
3. Load reg1=16'h1234, then WEn=0 with WData=16'hBBBB for 3 edges -> reg1 stays 16'h1234. Clear reg1 -> 16'h0000 and Wrap=0.
4. BYPASS=0: WEn=1, load reg3=16'h5A5A, RAddrA=RAddrB=3 -> QA=QB=old value before the edge, 16'h5A5A after. BYPASS=1 build, same stimulus -> QA=16'h5A5A in the same cycle.
5. Drop Reset 25ns after a clock edge while reg0=16'hAAAA and a pending inc -> QA (RAddrA=0) goes to 16'h0000 without waiting for the next edge. No increment is applied.
6. DEPTH=3 build: write WAddr=3 with 16'hCCCC -> no register changes. RAddrA=3 -> QA=16'h0000.
